seven_seg_scan_counter: RTL and testbench
=========================================

Name: seven_seg_scan_counter

Overview:
Downstream consumer of the wishbone wrapper's compare register. It holds a 4-digit BCD seconds counter whose tick period is set by a 24-bit compare value loaded over wishbone. It time-multiplexes the count onto one 7-segment pattern bus plus one-cold digit selects. Its outputs drive io_out through the wrapper's active mux. count_out is available for wishbone readback.

Parameters:
DEFAULT_COMPARE, 24'd10_000_000, prescaler period after reset (1 s at 10 MHz)
SCAN_DIV, 16'd10_000, clocks per digit during scanning; legal range 1..65535

Ports:
clk  input  1  system clock (wb_clk_i)
reset_n  input  1  asynchronous active-low reset
compare_in  input  24  new prescaler period, wbs_dat_i[23:0]
update_compare  input  1  one-cycle load strobe from a wishbone write to the compare address
enable  input  1  1 = prescaler runs; 0 = prescaler and count frozen
clear  input  1  synchronous clear of count and prescaler
led_out  output  7  segment pattern; bit0 = a … bit6 = g; active-high
digit_sel_n  output  4  one-cold digit select; bit0 = least significant digit
count_out  output  16  BCD count; [3:0] = units
second_tick  output  1  one-cycle pulse per prescaler wrap

Behaviour:
- Reset (async assert, sync release):
  - compare_reg = DEFAULT_COMPARE; prescaler = 0; count = 0; scan counter = 0; digit index = 0.
  - led_out = 7'h3F; digit_sel_n = 4'b1110; second_tick = 0.
- Compare load:
  - On a clk edge with update_compare = 1, compare_reg <= (compare_in == 0 ? 1 : compare_in).
  - The prescaler clears to 0 on the same edge.
  - The new period applies from the next cycle, so no overshoot when the new value is below the old prescaler value.
- Prescaler:
  - When enable = 1, counts 0..compare_reg-1.
  - On the edge where the prescaler equals compare_reg-1, it wraps to 0, count increments, and second_tick is registered high for exactly the following cycle.
  - compare_reg = 1 gives a tick every cycle.
- BCD increment:
  - Per-digit ripple carry: 9 -> 0 with carry.
  - 9999 -> 0000, no sticky overflow.
  - Digits never hold A–F.
- Priority on one edge: clear > update_compare > prescaler wrap.
  - clear: count = 0, prescaler = 0, second_tick = 0 next cycle, even if a wrap coincided.
  - update_compare with a coincident wrap: the load wins, no increment, no tick.
  - clear and update_compare together: both actions apply, compare loads, count = 0.
- enable = 0: prescaler and count hold; second_tick stays 0. Scanning continues.
- Scan:
  - Free-running scan counter 0..SCAN_DIV-1, independent of enable and clear.
  - On wrap, digit index advances 0->1->2->3->0.
  - digit_sel_n and led_out are both registered from the next index, so they change on the same edge and never glitch mismatched.
  - led_out follows a count change with 1-cycle latency.
- Segment decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; any other value: 00.
- count_out is the count register directly, with 0-cycle latency from its update.

Decomposition:
- Package seven_seg_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - widths COMPARE_W = 24, DIGITS = 4, BCD_W = 16.
- One combinational sub-module, seven_seg_decode (4-bit BCD in, 7-bit pattern out).
- Prescaler, BCD counter and scanner stay in the top module.

Test Plan:
1. Reset: hold reset_n low, release -> count_out = 16'h0000, led_out = 7'h3F, digit_sel_n = 4'b1110, second_tick = 0. Reassert reset mid-count -> all outputs return to reset values immediately, with no clk edge needed.
2. Period: DEFAULT_COMPARE = 5, enable = 1 -> second_tick every 5th cycle; after 12 ticks count_out = 16'h0012. Drop enable for 20 cycles -> no tick and count holds.
3. Load: pulse update_compare with compare_in = 0 -> period clamps to 1, tick every cycle. Then load 3 while the prescaler is at 4 of 5 -> next tick exactly 3 cycles later.
4. Wrap: compare = 1, run from 0 for 9999 ticks -> count_out = 16'h9999; next tick -> 16'h0000. Carry cases 0009->0010 and 0099->0100 are checked.
5. Collisions:
   - clear on the wrap edge at count 0041 -> count_out = 0000, no second_tick.
   - update_compare on the wrap edge -> no increment.
6. Scan: SCAN_DIV = 4, count = 16'h1234 -> digit_sel_n cycles 1110, 1101, 1011, 0111 every 4 cycles, with led_out 66, 4F, 5B, 06 respectively.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared widths and segment patterns for the seven-segment scan counter
// Contents: COMPARE_W / DIGITS / BCD_W widths, SEG_0..SEG_9 and SEG_BLANK patterns.
// Segment bit order: bit0 = a ... bit6 = g, active-high.
package seven_seg_pkg;

  localparam int COMPARE_W = 24;
  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - combinational BCD digit to seven-segment pattern decoder
// Ports:
//   bcd  in   4  BCD digit (values above 9 decode to blank)
//   seg  out  7  segment pattern, bit0 = a ... bit6 = g, active-high
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_counter.sv
// rtl/seven_seg_scan_counter.sv - prescaled 4-digit BCD counter with multiplexed seven-segment scan
// Ports:
//   clk             in   1   system clock
//   reset_n         in   1   asynchronous active-low reset
//   compare_in      in   24  new prescaler period
//   update_compare  in   1   one-cycle load strobe for compare_in
//   enable          in   1   1 = prescaler runs, 0 = prescaler and count frozen
//   clear           in   1   synchronous clear of count and prescaler
//   led_out         out  7   segment pattern of the selected digit
//   digit_sel_n     out  4   one-cold digit select, bit0 = units
//   count_out       out  16  BCD count, [3:0] = units
//   second_tick     out  1   one-cycle pulse per prescaler wrap
module seven_seg_scan_counter
  import seven_seg_pkg::*;
#(
  parameter logic [COMPARE_W-1:0] DEFAULT_COMPARE = 24'd10_000_000,
  parameter logic [15:0]          SCAN_DIV        = 16'd10_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COMPARE_W-1:0] compare_in,
  input  logic                 update_compare,
  input  logic                 enable,
  input  logic                 clear,
  output logic [6:0]           led_out,
  output logic [DIGITS-1:0]    digit_sel_n,
  output logic [BCD_W-1:0]     count_out,
  output logic                 second_tick
);

  logic [COMPARE_W-1:0] compare_reg;
  logic [COMPARE_W-1:0] prescaler;
  logic [BCD_W-1:0]     count;
  logic [BCD_W-1:0]     count_inc;
  logic                 prescale_wrap;

  logic [15:0]          scan_cnt;
  logic [1:0]           digit_idx;
  logic [1:0]           next_idx;
  logic                 scan_wrap;
  logic [3:0]           next_digit;
  logic [6:0]           next_seg;

  // >= rather than == keeps the prescaler bounded even if it ever sits above
  // the period; a load always clears it, so in practice this is an equality.
  assign prescale_wrap = enable && (prescaler >= (compare_reg - COMPARE_W'(1)));

  // Ripple-carry BCD increment: each digit rolls 9 -> 0 and passes the carry up,
  // so 9999 rolls cleanly to 0000.
  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[i*4 +: 4] >= 4'd9) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Priority: clear > compare load > prescaler wrap. A load and a clear on the
  // same edge both take effect; a load suppresses any coincident wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_reg <= DEFAULT_COMPARE;
      prescaler   <= '0;
      count       <= '0;
      second_tick <= 1'b0;
    end else begin
      second_tick <= 1'b0;
      if (update_compare) begin
        compare_reg <= (compare_in == '0) ? COMPARE_W'(1) : compare_in;
        prescaler   <= '0;
      end
      if (clear) begin
        count     <= '0;
        prescaler <= '0;
      end else if (!update_compare && enable) begin
        if (prescale_wrap) begin
          prescaler   <= '0;
          count       <= count_inc;
          second_tick <= 1'b1;
        end else begin
          prescaler <= prescaler + COMPARE_W'(1);
        end
      end
    end
  end

  assign count_out = count;

  // Scanner is free-running: it ignores enable and clear so the display never stalls.
  assign scan_wrap  = (scan_cnt >= (SCAN_DIV - 16'd1));
  assign next_idx   = scan_wrap ? (digit_idx + 2'd1) : digit_idx;
  assign next_digit = count[{next_idx, 2'b00} +: 4];

  seven_seg_decode u_decode (
    .bcd (next_digit),
    .seg (next_seg)
  );

  // Select and pattern are both registered from next_idx so they switch together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      led_out     <= SEG_0;
      digit_sel_n <= 4'b1110;
    end else begin
      scan_cnt    <= scan_wrap ? 16'd0 : (scan_cnt + 16'd1);
      digit_idx   <= next_idx;
      led_out     <= next_seg;
      digit_sel_n <= ~(4'b0001 << next_idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// tb/tb_seven_seg_scan_counter.sv - self-checking bench for seven_seg_scan_counter
module tb_seven_seg_scan_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] compare_in = '0;
  logic        update_compare = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  led_out;
  logic [3:0]  digit_sel_n;
  logic [15:0] count_out;
  logic        second_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  seven_seg_scan_counter #(
    .DEFAULT_COMPARE (24'd5),
    .SCAN_DIV        (16'd4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .compare_in     (compare_in),
    .update_compare (update_compare),
    .enable         (enable),
    .clear          (clear),
    .led_out        (led_out),
    .digit_sel_n    (digit_sel_n),
    .count_out      (count_out),
    .second_tick    (second_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bcd_of(int n);
    int m;
    logic [3:0] d3, d2, d1, d0;
    m  = n % 10000;
    d3 = 4'(m / 1000);
    d2 = 4'((m / 100) % 10);
    d1 = 4'((m / 10) % 10);
    d0 = 4'(m % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push_tick(input int at, input int n);
    exp_t e;
    e.at  = at;
    e.cnt = bcd_of(n);
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed tick must match the oldest expected (cycle, count).
  always @(negedge clk) begin
    if (reset_n === 1'b1 && second_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick at cycle %0d count=%h, required no tick", cyc, count_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.at != cyc || count_out !== e.cnt) begin
          errors++;
          $display("FAIL tick_scoreboard: got cycle %0d count %h, required cycle %0d count %h",
                   cyc, count_out, e.at, e.cnt);
        end
      end
    end
  end

  task automatic test_reset();
    int c;
    repeat (3) @(negedge clk);
    checks++;
    if (count_out !== 16'h0000 || led_out !== 7'h3F || digit_sel_n !== 4'b1110 || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: count=%h led=%h sel=%b tick=%b, required 0000 3f 1110 0",
               count_out, led_out, digit_sel_n, second_tick);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (count_out !== 16'h0000 || led_out !== 7'h3F || digit_sel_n !== 4'b1110 || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: count=%h led=%h sel=%b tick=%b, required 0000 3f 1110 0",
               count_out, led_out, digit_sel_n, second_tick);
    end
    enable = 1'b1;
    c = cyc;
    push_tick(c + 5, 1);
    repeat (7) @(negedge clk);
    checks++;
    if (count_out !== 16'h0001) begin
      errors++;
      $display("FAIL reset_precount: count=%h, required 0001", count_out);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (count_out !== 16'h0000 || led_out !== 7'h3F || digit_sel_n !== 4'b1110 || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%h led=%h sel=%b tick=%b, required 0000 3f 1110 0",
               count_out, led_out, digit_sel_n, second_tick);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_period();
    int c;
    @(negedge clk);
    enable = 1'b1;
    c = cyc;
    for (int k = 1; k <= 12; k++) push_tick(c + 5 * k, model_cnt + k);
    model_cnt += 12;
    repeat (60) @(negedge clk);
    checks++;
    if (count_out !== 16'h0012) begin
      errors++;
      $display("FAIL period_count: count=%h, required 0012", count_out);
    end
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (count_out !== 16'h0012 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL period_hold: count=%h pending=%0d, required 0012 and 0 pending", count_out, exp_q.size());
    end
  endtask

  task automatic test_load();
    int d;
    @(negedge clk);
    d = cyc;
    compare_in = 24'd0;
    update_compare = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) push_tick(d + 1 + k, model_cnt + k);
    @(negedge clk);
    update_compare = 1'b0;
    repeat (5) @(negedge clk);
    // Load 5 on an edge that is also a wrap for period 1: the load must win.
    compare_in = 24'd5;
    update_compare = 1'b1;
    @(negedge clk);
    update_compare = 1'b0;
    checks++;
    if (count_out !== bcd_of(model_cnt + 5) || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL load_collision: count=%h tick=%b, required %h 0", count_out, second_tick, bcd_of(model_cnt + 5));
    end
    // Reload 3 while the prescaler holds 4 of 5: next tick exactly 3 cycles later.
    push_tick(d + 15, model_cnt + 6);
    push_tick(d + 18, model_cnt + 7);
    repeat (4) @(negedge clk);
    compare_in = 24'd3;
    update_compare = 1'b1;
    @(negedge clk);
    update_compare = 1'b0;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    model_cnt += 7;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || count_out !== bcd_of(model_cnt)) begin
      errors++;
      $display("FAIL load_done: count=%h pending=%0d, required %h and 0 pending", count_out, exp_q.size(), bcd_of(model_cnt));
    end
  endtask

  task automatic test_wrap();
    int e;
    @(negedge clk);
    e = cyc;
    clear = 1'b1;
    update_compare = 1'b1;
    compare_in = 24'd1;
    enable = 1'b1;
    for (int k = 1; k <= 10000; k++) push_tick(e + 1 + k, k);
    @(negedge clk);
    clear = 1'b0;
    update_compare = 1'b0;
    checks++;
    if (count_out !== 16'h0000 || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear_load: count=%h tick=%b, required 0000 0", count_out, second_tick);
    end
    for (int k = 1; k <= 10000; k++) begin
      @(negedge clk);
      if (k == 9 || k == 10 || k == 99 || k == 100 || k == 9999 || k == 10000) begin
        checks++;
        if (count_out !== bcd_of(k)) begin
          errors++;
          $display("FAIL wrap_carry_%0d: count=%h, required %h", k, count_out, bcd_of(k));
        end
      end
    end
    enable = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_collision_clear();
    int f;
    @(negedge clk);
    f = cyc;
    enable = 1'b1;
    for (int k = 1; k <= 41; k++) push_tick(f + k, k);
    repeat (41) @(negedge clk);
    checks++;
    if (count_out !== 16'h0041) begin
      errors++;
      $display("FAIL clear_precount: count=%h, required 0041", count_out);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enable = 1'b0;
    checks++;
    if (count_out !== 16'h0000 || second_tick !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_wrap: count=%h tick=%b, required 0000 0", count_out, second_tick);
    end
    model_cnt = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_pending: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_scan();
    int s;
    logic [3:0] prev;
    logic found;
    logic [3:0] sel_tab [4];
    logic [6:0] led_tab [4];
    sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    led_tab = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    @(negedge clk);
    s = cyc;
    enable = 1'b1;
    for (int k = 1; k <= 1234; k++) push_tick(s + k, k);
    repeat (1234) @(negedge clk);
    enable = 1'b0;
    checks++;
    if (count_out !== 16'h1234) begin
      errors++;
      $display("FAIL scan_count: count=%h, required 1234", count_out);
    end
    prev = digit_sel_n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev === 4'b0111 && digit_sel_n === 4'b1110) found = 1'b1;
      prev = digit_sel_n;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_sync: no 0111->1110 transition within 40 cycles, last sel=%b", digit_sel_n);
    end else begin
      for (int p = 0; p < 4; p++) begin
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (digit_sel_n !== sel_tab[p] || led_out !== led_tab[p]) begin
            errors++;
            $display("FAIL scan_digit%0d_cyc%0d: sel=%b led=%h, required %b %h",
                     p, j, digit_sel_n, led_out, sel_tab[p], led_tab[p]);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_load();
    test_wrap();
    test_collision_clear();
    test_scan();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: pending=%0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
